branch_pred_table: RTL and testbench
====================================

Name: branch_pred_table

Overview:
- Storage end of the 2-bit branch predictor.
- Holds per-entry valid, tag, target and 2-bit saturating counter, indexed by PC.
- Fetch stage reads it combinationally. A registered fetch-to-decode copy feeds the branch unit's decode-stage inputs.
- Consumes the branch unit's write enables:
  - wrt allocates or replaces an entry.
  - wrp updates the counter.

Parameters:
- ENTRIES, 16, number of table entries; power of two, >=2.
- IDX_W, $clog2(ENTRIES), index width taken from pc[IDX_W+1:2].
- PC_W, 32, PC and target width.
- TAG_W, PC_W-IDX_W-2, tag width taken from pc[PC_W-1:IDX_W+2].

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_f  in  PC_W  fetch-stage PC.
- hit_f  out  1  fetch-stage hit: entry valid and tag match.
- cnt_f  out  2  counter of the indexed entry; 0 when there is no hit.
- target_f  out  PC_W  stored target; 0 when there is no hit.
- stall  in  1  hold the decode copy.
- flush  in  1  clear the decode copy.
- hit_d  out  1  registered hit_f.
- cnt_d  out  2  registered cnt_f.
- pc_d  out  PC_W  registered pc_f.
- wrt  in  1  allocate entry for pc_d.
- wrp  in  1  update counter of the entry for pc_d.
- taken  in  1  resolved branch outcome.
- target_in  in  PC_W  resolved target, written on wrt.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - All valid bits 0, all counters 2'b01.
  - hit_d=0, cnt_d=0, pc_d=0.
  - Tag and target arrays are not reset; valid gates them.
  - hit_f, cnt_f and target_f are therefore 0 immediately.
- Read port, combinational:
  - idx=pc_f[IDX_W+1:2].
  - hit_f = valid[idx] && tag[idx]==pc_f tag bits.
  - cnt_f and target_f are masked to 0 when hit_f=0.
- F->D register, priority flush > stall > load:
  - flush: hit_d=0, cnt_d=0, pc_d=0.
  - stall: hold all decode outputs.
  - otherwise: load hit_f, cnt_f and pc_f.
  - Latency is 1 cycle from fetch to decode.
- Writes use the index and tag of pc_d. The branch unit resolves in decode.
- wrt=1, with wrp either value:
  - Set valid=1, tag, target=target_in.
  - Counter initialised to 2'b10 if taken, else 2'b01 (weak states).
  - An existing entry at that index is overwritten; there is no associativity.
- wrp=1, wrt=0:
  - Applied only if the entry at that index is valid and its tag matches pc_d.
  - On a mismatch the write is silently dropped.
- Counter update is saturating:
  - taken: 11 stays 11; otherwise +1.
  - not taken: 00 stays 00; otherwise -1.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- stall=1 does not block writes. flush=1 does not block writes in the same cycle; the writes belong to the instruction being resolved.
- Read-during-write to the same index (without the optional feature):
  - The read returns the old contents.
  - The new value is visible the following cycle.
- Reset asserted mid-operation discards all entries and pending decode state. There is no recovery of table contents.
- pc bits [1:0] are ignored.

Optional Feature:
- Macro BPT_BYPASS_EN.
- Defined:
  - When a wrt or wrp commits this cycle to idx(pc_f), and the tag matches where the write defines it, hit_f, cnt_f and target_f reflect the post-write value in the same cycle.
  - A wrp dropped on tag mismatch does not forward.
- Undefined: old-value read as specified above.
- Only the fetch outputs change; the array timing is identical either way.

Decomposition:
- Package bp_pkg holds:
  - Counter encodings CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
  - Counter reset value CNT_RST=CNT_WNT.
  - Typedef bpt_entry_t {valid, tag, target, cnt}.
- One sub-module, bp_sat_cnt2: combinational 2-bit saturating next-state (cnt, taken -> cnt_next).
  - Shared with the branch unit's decode-side counter logic.

Test Plan:
- Reset then pc_f=0x100 -> hit_f=0, cnt_f=0, target_f=0; next cycle hit_d=0, pc_d=0x100.
- Cycle 1, with no stall and no flush: pc_f=0x100, then pc_d=0x100. Cycle 2: wrt=1, taken=1, target_in=0x200. Cycle 3: pc_f=0x100 -> hit_f=1, cnt_f=2'b10, target_f=0x200; a different tag at the same index (0x140 with ENTRIES=16) -> hit_f=0.
- Entry at 0x100 with cnt=10, pc_d=0x100: four wrp with taken=1 -> cnt 11,11,11,11; then four with taken=0 -> 10,01,00,00; saturation holds at both ends.
- wrp=1 with pc_d=0x140 while the index holds 0x100 -> entry 0x100 unchanged. wrt=1 at 0x140 with taken=0 -> replaces it, cnt=01, 0x100 now misses.
- stall=1 for 3 cycles while pc_f changes -> hit_d, cnt_d, pc_d held. flush=1 together with stall=1 -> decode outputs cleared next edge. Async rst_n pulse mid-cycle -> outputs 0 immediately, without waiting for clk.
- BPT_BYPASS_EN defined: pc_f=pc_d=0x100 with wrt=1, taken=1, target_in=0x300 -> same cycle hit_f=1, cnt_f=10, target_f=0x300. Undefined: same cycle hit_f=0, next cycle hit_f=1.

Source files
------------

// File: rtl/branch_pred_table_pkg.sv
// Shared definitions for the branch predictor table: counter encodings,
// the reset/allocation counter values and the entry record.
package bp_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;
  localparam logic [1:0] CNT_RST = CNT_WNT;

  localparam int BPT_ENTRIES = 16;
  localparam int BPT_PC_W    = 32;
  localparam int BPT_IDX_W   = $clog2(BPT_ENTRIES);
  localparam int BPT_TAG_W   = BPT_PC_W - BPT_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [BPT_TAG_W-1:0] tag;
    logic [BPT_PC_W-1:0]  target;
    logic [1:0]           cnt;
  } bpt_entry_t;

  // A freshly allocated entry starts in the weak state of its first outcome.
  function automatic logic [1:0] cnt_alloc(input logic taken);
    return taken ? CNT_WT : CNT_WNT;
  endfunction

endpackage

// File: rtl/branch_pred_table_if.sv
// Bundle between fetch/decode/branch unit and the predictor table.
interface branch_pred_table_if #(
  parameter int PC_W = 32
);

  // No valid/ready handshake: the fetch read is purely combinational, the
  // decode copy advances every cycle unless stall/flush, and wrt/wrp are
  // single-cycle strobes that always commit (wrp only on a tag match).
  logic [PC_W-1:0] pc_f;
  logic            hit_f;
  logic [1:0]      cnt_f;
  logic [PC_W-1:0] target_f;
  logic            stall;
  logic            flush;
  logic            hit_d;
  logic [1:0]      cnt_d;
  logic [PC_W-1:0] pc_d;
  logic            wrt;
  logic            wrp;
  logic            taken;
  logic [PC_W-1:0] target_in;

  modport master (
    output pc_f, stall, flush, wrt, wrp, taken, target_in,
    input  hit_f, cnt_f, target_f, hit_d, cnt_d, pc_d
  );

  modport slave (
    input  pc_f, stall, flush, wrt, wrp, taken, target_in,
    output hit_f, cnt_f, target_f, hit_d, cnt_d, pc_d
  );

endinterface

// File: rtl/branch_pred_table_sat_cnt2.sv
// 2-bit saturating counter next-state, also used by the branch unit's
// decode-side counter logic.
module bp_sat_cnt2
  import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_pred_table.sv
// Direct-mapped branch predictor table with a combinational fetch read and a
// registered fetch-to-decode copy. Define BPT_BYPASS_EN to forward same-cycle writes to the fetch read.
module branch_pred_table
  import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int PC_W    = 32,
    parameter int TAG_W   = PC_W - IDX_W - 2
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_pred_table_if.slave bus
);

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];

    logic               hit_d_q;
    logic [1:0]         cnt_d_q;
    logic [PC_W-1:0]    pc_d_q;

    logic [IDX_W-1:0]   idx_f;
    logic [IDX_W-1:0]   idx_d;
    logic [TAG_W-1:0]   tag_f;
    logic [TAG_W-1:0]   tag_d;

    assign idx_f = bus.pc_f[IDX_W+1:2];
    assign tag_f = bus.pc_f[PC_W-1:IDX_W+2];
    assign idx_d = pc_d_q[IDX_W+1:2];
    assign tag_d = pc_d_q[PC_W-1:IDX_W+2];

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{bus.pc_f[1:0], pc_d_q[1:0]};

    // Writes are addressed by the instruction sitting in decode.
    logic       wr_match;
    logic       wr_commit;
    logic [1:0] cnt_upd;
    logic [1:0] cnt_new;

    assign wr_match  = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
    assign wr_commit = bus.wrt || (bus.wrp && wr_match);

    bp_sat_cnt2 u_sat_cnt2 (
        .cnt      (cnt_q[idx_d]),
        .taken    (bus.taken),
        .cnt_next (cnt_upd)
    );

    assign cnt_new = bus.wrt ? cnt_alloc(bus.taken) : cnt_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RST;
        end else if (wr_commit) begin
            valid_q[idx_d] <= 1'b1;
            cnt_q[idx_d]   <= cnt_new;
        end
    end

    // Tag and target stay unreset; the valid bit gates them.
    always_ff @(posedge clk) begin
        if (bus.wrt) begin
            tag_q[idx_d]    <= tag_d;
            target_q[idx_d] <= bus.target_in;
        end
    end

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    logic [1:0]       rd_cnt;
    logic             rd_hit;

    always_comb begin
        rd_valid  = valid_q[idx_f];
        rd_tag    = tag_q[idx_f];
        rd_target = target_q[idx_f];
        rd_cnt    = cnt_q[idx_f];
`ifdef BPT_BYPASS_EN
        // Present the post-write entry when this cycle's write lands on our index.
        if (wr_commit && (idx_d == idx_f)) begin
            rd_valid = 1'b1;
            rd_cnt   = cnt_new;
            if (bus.wrt) begin
                rd_tag    = tag_d;
                rd_target = bus.target_in;
            end
        end
`endif
        rd_hit = rd_valid && (rd_tag == tag_f);
    end

    assign bus.hit_f    = rd_hit;
    assign bus.cnt_f    = rd_hit ? rd_cnt : 2'b00;
    assign bus.target_f = rd_hit ? rd_target : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_d_q <= 1'b0;
            cnt_d_q <= 2'b00;
            pc_d_q  <= '0;
        end else if (bus.flush) begin
            hit_d_q <= 1'b0;
            cnt_d_q <= 2'b00;
            pc_d_q  <= '0;
        end else if (!bus.stall) begin
            hit_d_q <= bus.hit_f;
            cnt_d_q <= bus.cnt_f;
            pc_d_q  <= bus.pc_f;
        end
    end

    assign bus.hit_d = hit_d_q;
    assign bus.cnt_d = cnt_d_q;
    assign bus.pc_d  = pc_d_q;

endmodule

// File: tb/tb_branch_pred_table.sv
// Directed and randomised checks of branch_pred_table against a small
// behavioural table model; expectations flow through a scoreboard queue.
`timescale 1ns/100ps
module tb_branch_pred_table;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_pred_table_if #(.PC_W(32)) bus ();

    branch_pred_table #(.ENTRIES(16), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];

    task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [39:0] obs);
        if (exp_q.size() == 0) check_val({tag, "_noexp"}, obs, 40'hx);
        else check_val(tag, obs, exp_q.pop_front());
    endtask

    function automatic logic [39:0] vec(input logic h, input logic [1:0] c, input logic [31:0] v);
        return {5'd0, h, c, v};
    endfunction

    function automatic logic [39:0] obs_f();
        return {5'd0, bus.hit_f, bus.cnt_f, bus.target_f};
    endfunction

    function automatic logic [39:0] obs_d();
        return {5'd0, bus.hit_d, bus.cnt_d, bus.pc_d};
    endfunction

    task automatic chk_f(input string tag, input logic h, input logic [1:0] c, input logic [31:0] t);
        exp_q.push_back(vec(h, c, t));
        pop_chk(tag, obs_f());
    endtask

    task automatic chk_d(input string tag, input logic h, input logic [1:0] c, input logic [31:0] p);
        exp_q.push_back(vec(h, c, p));
        pop_chk(tag, obs_d());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
        case ({t, c})
            3'b000: return 2'b00;
            3'b001: return 2'b00;
            3'b010: return 2'b01;
            3'b011: return 2'b10;
            3'b100: return 2'b01;
            3'b101: return 2'b10;
            3'b110: return 2'b11;
            default: return 2'b11;
        endcase
    endfunction

    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_cnt   [16];
    logic        md_hit;
    logic [1:0]  md_cnt;
    logic [31:0] md_pc;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] sat_exp [8];
        sat_exp = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};

        bus.pc_f = 32'h100; bus.stall = 0; bus.flush = 0;
        bus.wrt = 0; bus.wrp = 0; bus.taken = 0; bus.target_in = '0;
        #3;
        chk_f("rst_f", 0, 2'b00, 32'h0);
        chk_d("rst_d", 0, 2'b00, 32'h0);
        @(negedge clk);
        rst_n = 1;

        // first fetch reaches decode one edge later
        exp_q.push_back(vec(0, 2'b00, 32'h100));
        tick();
        pop_chk("lat_d", obs_d());

        bus.wrt = 1; bus.taken = 1; bus.target_in = 32'h200;
        #1;
`ifdef BPT_BYPASS_EN
        chk_f("rdw_same", 1, 2'b10, 32'h200);
        exp_q.push_back(vec(1, 2'b10, 32'h100));
`else
        chk_f("rdw_same", 0, 2'b00, 32'h0);
        exp_q.push_back(vec(0, 2'b00, 32'h100));
`endif
        tick();
        bus.wrt = 0;
        #1;
        pop_chk("alloc_d", obs_d());
        chk_f("alloc_hit", 1, 2'b10, 32'h200);
        bus.pc_f = 32'h140; #1;
        chk_f("alias_miss", 0, 2'b00, 32'h0);
        bus.pc_f = 32'h100; #1;

        for (int i = 0; i < 8; i++) begin
            bus.wrp = 1; bus.taken = (i < 4);
            tick();
            bus.wrp = 0; #1;
            chk_f($sformatf("sat_%0d", i), 1, sat_exp[i], 32'h200);
        end

        // counter update to a mismatching tag is dropped
        bus.pc_f = 32'h140;
        tick();
        bus.wrp = 1; bus.taken = 1; #1;
        chk_f("drop_nofwd", 0, 2'b00, 32'h0);
        tick();
        bus.wrp = 0; bus.pc_f = 32'h100; #1;
        chk_f("drop_keep", 1, 2'b00, 32'h200);

        bus.wrt = 1; bus.taken = 0; bus.target_in = 32'h444; #1;
`ifdef BPT_BYPASS_EN
        chk_f("repl_same", 0, 2'b00, 32'h0);
`else
        chk_f("repl_same", 1, 2'b00, 32'h200);
`endif
        tick();
        bus.wrt = 0; #1;
        chk_f("repl_old_miss", 0, 2'b00, 32'h0);
        bus.pc_f = 32'h140; #1;
        chk_f("repl_new", 1, 2'b01, 32'h444);

        exp_q.push_back(vec(1, 2'b01, 32'h140));
        tick();
        pop_chk("stall_load", obs_d());
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_f = 32'h8 << (2 * i);
            exp_q.push_back(vec(1, 2'b01, 32'h140));
            tick();
            pop_chk($sformatf("stall_hold_%0d", i), obs_d());
        end
        bus.flush = 1;
        exp_q.push_back(vec(0, 2'b00, 32'h0));
        tick();
        pop_chk("flush_clr", obs_d());
        bus.flush = 0; bus.stall = 0;

        // a write in a flush cycle still lands
        bus.pc_f = 32'h140;
        tick();
        bus.wrp = 1; bus.taken = 1; bus.flush = 1;
        tick();
        bus.wrp = 0; bus.flush = 0; #1;
        chk_f("flush_wr", 1, 2'b10, 32'h444);
        chk_d("flush_wr_d", 0, 2'b00, 32'h0);

        exp_q.push_back(vec(1, 2'b10, 32'h140));
        tick();
        pop_chk("pre_rst_d", obs_d());
        #1 rst_n = 0;
        #1;
        chk_f("arst_f", 0, 2'b00, 32'h0);
        chk_d("arst_d", 0, 2'b00, 32'h0);
        #1 rst_n = 1;
        #1;
        chk_f("arst_lost", 0, 2'b00, 32'h0);

        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 2'b01;
        end
        md_hit = 0; md_cnt = 2'b00; md_pc = '0;

        for (int n = 0; n < 400; n++) begin
            logic [31:0] pcf;
            logic [3:0]  fi, di;
            logic [25:0] ft, dt;
            logic        dhit, commit, ev, eh;
            logic [1:0]  ncnt, ecnt;
            logic [25:0] etag;
            logic [31:0] etgt;
            logic        nh;
            logic [1:0]  nc;
            logic [31:0] np;

            pcf = (32'(4 + $urandom_range(0, 1)) << 6) | (32'($urandom_range(0, 3)) << 2)
                  | 32'($urandom_range(0, 3));
            bus.pc_f      = pcf;
            bus.wrt       = ($urandom_range(0, 4) == 0);
            bus.wrp       = ($urandom_range(0, 2) == 0);
            bus.taken     = 1'($urandom_range(0, 1));
            bus.target_in = $urandom;
            bus.stall     = ($urandom_range(0, 4) == 0);
            bus.flush     = ($urandom_range(0, 9) == 0);

            di = md_pc[5:2]; dt = md_pc[31:6];
            fi = pcf[5:2];   ft = pcf[31:6];
            dhit   = m_valid[di] && (m_tag[di] == dt);
            commit = bus.wrt || (bus.wrp && dhit);
            ncnt   = bus.wrt ? (bus.taken ? 2'b10 : 2'b01) : m_sat(m_cnt[di], bus.taken);

            ev = m_valid[fi]; etag = m_tag[fi]; etgt = m_tgt[fi]; ecnt = m_cnt[fi];
`ifdef BPT_BYPASS_EN
            if (commit && (di == fi)) begin
                ev = 1; ecnt = ncnt;
                if (bus.wrt) begin etag = dt; etgt = bus.target_in; end
            end
`endif
            eh = ev && (etag == ft);
            #1;
            chk_f($sformatf("rnd_f_%0d", n), eh, eh ? ecnt : 2'b00, eh ? etgt : 32'h0);

            if (bus.flush) begin nh = 0; nc = 2'b00; np = '0; end
            else if (bus.stall) begin nh = md_hit; nc = md_cnt; np = md_pc; end
            else begin nh = eh; nc = eh ? ecnt : 2'b00; np = pcf; end
            exp_q.push_back(vec(nh, nc, np));

            @(posedge clk);
            if (commit) begin
                m_valid[di] = 1; m_cnt[di] = ncnt;
                if (bus.wrt) begin m_tag[di] = dt; m_tgt[di] = bus.target_in; end
            end
            md_hit = nh; md_cnt = nc; md_pc = np;
            #1;
            pop_chk($sformatf("rnd_d_%0d", n), obs_d());
        end

        if (exp_q.size() != 0) check_val("sb_drain", 40'(exp_q.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
